// File: rtl/csa_accumulator_if.sv
// Operand stream in, resolved group result out, both valid/ready.
// The accumulator takes the slave side; the source/sink takes the master side.
interface csa_accumulator_if #(
  parameter int N     = 4,
  parameter int ACC_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [4:0]       out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/csa_accumulator.sv
// Streaming group accumulator: 3:2 carry-save fold per beat, then a resolve to one sum.
// Build macro CSA_ACC_FAST_RESOLVE_EN selects a one-cycle full-adder resolve instead of bit-serial.
module csa_accumulator #(
  parameter int N       = 4,
  parameter int ACC_W   = 8,
  parameter int MAX_OPS = 17
) (
  input  logic               clk,
  input  logic               rst,
  csa_accumulator_if.slave   bus
);

  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q;
  logic [ACC_W-1:0] s_q, c_q, res_q;
  logic [ACC_W-1:0] x, s_d, c_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             accept;

`ifndef CSA_ACC_FAST_RESOLVE_EN
  localparam int IW = (ACC_W > 1) ? $clog2(ACC_W) : 1;
  logic [IW-1:0] i_q;
  logic          k_q;
  logic          s_bit, c_bit;

  assign s_bit = s_q[i_q];
  assign c_bit = c_q[i_q];
`endif

  assign x = ACC_W'(bus.in_data);

  // Carry-save compression: the carry vector is shifted up one bit and its top bit dropped.
  assign c_d[0] = 1'b0;
  for (genvar gi = 0; gi < ACC_W; gi++) begin : g_csa
    assign s_d[gi] = s_q[gi] ^ c_q[gi] ^ x[gi];
    if (gi > 0) begin : g_carry
      assign c_d[gi] = (s_q[gi-1] & c_q[gi-1]) | (s_q[gi-1] & x[gi-1]) | (c_q[gi-1] & x[gi-1]);
    end
  end

  assign cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
  assign ovf_d = ovf_q | (32'(cnt_q) >= 32'(MAX_OPS));

  // Reset gates in_ready so nothing is taken while the block is held.
  assign bus.in_ready  = (state_q == ACCUM) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = res_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifndef CSA_ACC_FAST_RESOLVE_EN
      i_q     <= '0;
      k_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            s_q   <= s_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (bus.in_last) begin
              state_q <= RESOLVE;
`ifndef CSA_ACC_FAST_RESOLVE_EN
              i_q     <= '0;
              k_q     <= 1'b0;
`endif
            end
          end
        end
        RESOLVE: begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
          res_q   <= s_q + c_q;
          state_q <= DONE;
`else
          // Result bits enter at the top and shift down; bit 0 lands last.
          res_q <= {s_bit ^ c_bit ^ k_q, res_q[ACC_W-1:1]};
          k_q   <= (s_bit & c_bit) | (s_bit & k_q) | (c_bit & k_q);
          i_q   <= i_q + 1'b1;
          if (i_q == IW'(ACC_W - 1)) begin
            state_q <= DONE;
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized and directed bench for csa_accumulator against an arithmetic group-sum model.
module tb_csa_accumulator;
  localparam int N       = 4;
  localparam int ACC_W   = 8;
  localparam int MAX_OPS = 17;
`ifdef CSA_ACC_FAST_RESOLVE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = ACC_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ops_q[$];

  always #5 clk = ~clk;

  csa_accumulator_if #(.N(N), .ACC_W(ACC_W)) bus ();

  csa_accumulator #(.N(N), .ACC_W(ACC_W), .MAX_OPS(MAX_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers every operand in ops_q as one group; returns after the last beat is accepted.
  task automatic send_beats(input string tag);
    int w;
    for (int j = 0; j < ops_q.size(); j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = N'(ops_q[j]);
      bus.in_last  = (j == ops_q.size() - 1);
      w = 0;
      while (!bus.in_ready && w < 100) begin
        step();
        w++;
      end
      if (w >= 100) check({tag, "_in_ready_timeout"}, 0, 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // hold < 0: out_ready stays high (back-to-back); otherwise stall hold cycles before accepting.
  task automatic run_group(input string tag, input int hold);
    int n, exp_sum, exp_cnt, exp_ovf, lat;
    n       = ops_q.size();
    exp_sum = 0;
    foreach (ops_q[j]) exp_sum += ops_q[j];
    exp_sum = exp_sum % (1 << ACC_W);
    exp_cnt = (n > 31) ? 31 : n;
    exp_ovf = (n > MAX_OPS) ? 1 : 0;

    bus.out_ready = (hold < 0);
    send_beats(tag);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_sum"}, bus.out_sum, exp_sum);
    check({tag, "_count"}, bus.out_count, exp_cnt);
    check({tag, "_ovf"}, bus.out_ovf, exp_ovf);
    if (hold >= 0) begin
      for (int h = 0; h < hold; h++) begin
        step();
        check({tag, "_hold"}, {bus.out_valid, bus.in_ready, bus.out_sum},
              {1'b1, 1'b0, 8'(exp_sum)});
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
    end else begin
      step();
    end
    $display("group %s beats=%0d sum=%0d count=%0d ovf=%0d", tag, n, bus.out_sum, exp_cnt, exp_ovf);
    check({tag, "_after_hs"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    ops_q = '{2, 1, 4};
    run_group("basic", 0);

    ops_q = '{3, 2, 0};
    run_group("b2b_a", -1);
    ops_q = '{10, 1, 2};
    run_group("b2b_b", -1);
    ops_q = '{13, 9, 3};
    run_group("b2b_c", -1);

    ops_q = {};
    repeat (17) ops_q.push_back(15);
    run_group("max17", 0);
    ops_q = {};
    repeat (18) ops_q.push_back(15);
    run_group("ovf18", 1);
    ops_q = {};
    repeat (33) ops_q.push_back(1);
    run_group("sat33", 0);

    ops_q = '{9};
    run_group("single_bp", 20);

    // Reset in the middle of resolving: the aborted group must never surface.
    ops_q = '{7, 7};
    send_beats("abort");
    step();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd3;
    step();
    check("abort_rst_in_ready", bus.in_ready, 0);
    check("abort_rst_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (12) begin
      step();
      if (bus.out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    check("abort_count_clear", bus.out_count, 0);
    ops_q = '{4, 5};
    run_group("after_abort", 0);

    for (int g = 0; g < 30; g++) begin
      int nb;
      nb = $urandom_range(1, 20);
      ops_q = {};
      repeat (nb) ops_q.push_back($urandom_range(0, 15));
      run_group($sformatf("rand%0d", g), int'($urandom_range(0, 4)) - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
